// File: rtl/float32_acc_pkg.sv
// Shared binary32 field layout, special encodings and FSM states for the
// float32 accumulator.
package float32_acc_pkg;

    localparam int DATA_W      = 32;
    localparam int SIGN_BIT    = 31;
    localparam int EXP_HI      = 30;
    localparam int EXP_LO      = 23;
    localparam int MAN_HI      = 22;
    localparam int EXP_W       = 8;
    localparam int SIG_W       = 24;
    localparam int EXP_BIAS    = 127;
    localparam int ALIGN_LIMIT = 25;

    localparam logic [EXP_W-1:0]  EXP_SPECIAL = 8'hFF;
    localparam logic [DATA_W-1:0] F32_ZERO    = 32'h0000_0000;
    localparam logic [DATA_W-1:0] F32_QNAN    = 32'h7FC0_0000;
    localparam logic [DATA_W-1:0] F32_POS_INF = 32'h7F80_0000;
    localparam logic [DATA_W-1:0] F32_NEG_INF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        OUT
    } state_t;

    function automatic logic [DATA_W-1:0] inf_of(input logic sign);
        return sign ? F32_NEG_INF : F32_POS_INF;
    endfunction

endpackage

// File: rtl/f32_unpack.sv
// Combinational binary32 field splitter; denormals are flushed to an unsigned zero.
module f32_unpack
    import float32_acc_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [SIG_W-1:0]  man,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan
);

    logic [EXP_W-1:0] exp_field;
    logic [MAN_HI:0]  frac;

    assign exp_field = value[EXP_HI:EXP_LO];
    assign frac      = value[MAN_HI:0];

    assign is_zero = (exp_field == '0);
    assign is_inf  = (exp_field == EXP_SPECIAL) && (frac == '0);
    assign is_nan  = (exp_field == EXP_SPECIAL) && (frac != '0);
    assign sign    = is_zero ? 1'b0 : value[SIGN_BIT];
    assign exp     = exp_field;
    assign man     = is_zero ? '0 : {1'b1, frac};

endmodule

// File: rtl/float32_acc.sv
// Sequential binary32 accumulator: one operand per ALIGN/ADD/NORM pass,
// truncating arithmetic, group sum presented on a valid/ready output.
module float32_acc
    import float32_acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    state_t state, next_state;

    logic [DATA_W-1:0] opnd;
    logic              last_r;
    logic [DATA_W-1:0] acc;
    logic              special;

    logic             i_sign, i_zero, i_inf, i_nan;
    logic [EXP_W-1:0] i_exp;
    logic [SIG_W-1:0] i_man;
    logic             a_sign, a_zero, a_inf, a_nan;
    logic [EXP_W-1:0] a_exp;
    logic [SIG_W-1:0] a_man;

    f32_unpack u_unpack_in (
        .value   (opnd),
        .sign    (i_sign),
        .exp     (i_exp),
        .man     (i_man),
        .is_zero (i_zero),
        .is_inf  (i_inf),
        .is_nan  (i_nan)
    );

    f32_unpack u_unpack_acc (
        .value   (acc),
        .sign    (a_sign),
        .exp     (a_exp),
        .man     (a_man),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan)
    );

    // Truncating pack: no guard bits, so the result is just the kept fields.
    function automatic logic [DATA_W-1:0] truncate_pack(
        input logic                    sign,
        input logic signed [EXP_W+1:0] exp,
        input logic [SIG_W-1:0]        man,
        input logic                    spec_hit,
        input logic [DATA_W-1:0]       spec_val
    );
        if (spec_hit)
            return spec_val;
        if ((man == '0) || (exp < 10'sd1))
            return F32_ZERO;
        if (exp >= 10'sd255)
            return inf_of(sign);
        return {sign, exp[EXP_W-1:0], man[MAN_HI:0]};
    endfunction

    // ALIGN: order operands by magnitude and shift the smaller one
    logic                    acc_big;
    logic                    big_sign_c;
    logic [EXP_W-1:0]        big_exp_c, small_exp_c, exp_diff;
    logic [SIG_W-1:0]        big_man_c, small_man_c, aligned_c;
    logic                    spec_hit_c;
    logic [DATA_W-1:0]       spec_val_c;

    always_comb begin
        acc_big     = !a_zero && (i_zero || ({a_exp, a_man} >= {i_exp, i_man}));
        big_sign_c  = acc_big ? a_sign : i_sign;
        big_exp_c   = acc_big ? a_exp  : i_exp;
        big_man_c   = acc_big ? a_man  : i_man;
        small_exp_c = acc_big ? i_exp  : a_exp;
        small_man_c = acc_big ? i_man  : a_man;
        exp_diff    = big_exp_c - small_exp_c;
        aligned_c   = (exp_diff >= EXP_W'(ALIGN_LIMIT)) ? '0 : (small_man_c >> exp_diff);
        spec_hit_c  = special | i_inf | i_nan;
        if (a_nan || i_nan)
            spec_val_c = F32_QNAN;
        else if (a_inf && i_inf && (a_sign != i_sign))
            spec_val_c = F32_QNAN;
        else if (i_inf)
            spec_val_c = inf_of(i_sign);
        else
            spec_val_c = acc;
    end

    logic                    big_sign_r, eff_sub_r, spec_hit_r;
    logic [EXP_W-1:0]        big_exp_r;
    logic [SIG_W-1:0]        big_man_r, small_man_r;
    logic [DATA_W-1:0]       spec_val_r;

    // ADD: 25-bit magnitude sum/difference
    logic [SIG_W:0] sum_c;

    assign sum_c = eff_sub_r ? ({1'b0, big_man_r} - {1'b0, small_man_r})
                             : ({1'b0, big_man_r} + {1'b0, small_man_r});

    logic                    work_sign;
    logic signed [EXP_W+1:0] work_exp;
    logic [SIG_W-1:0]        work_man;

    // NORM: one left shift per cycle until the hidden bit is set
    logic              norm_done;
    logic [DATA_W-1:0] result;

    assign norm_done = spec_hit_r || (work_man == '0) || work_man[SIG_W-1];
    assign result    = truncate_pack(work_sign, work_exp, work_man, spec_hit_r, spec_val_r);

    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (in_valid) begin
                    opnd   <= in_data;
                    last_r <= in_last;
                end
            end
            ALIGN: begin
                big_sign_r  <= big_sign_c;
                big_exp_r   <= big_exp_c;
                big_man_r   <= big_man_c;
                small_man_r <= aligned_c;
                eff_sub_r   <= (a_sign != i_sign);
                spec_hit_r  <= spec_hit_c;
                spec_val_r  <= spec_val_c;
            end
            ADD: begin
                work_sign <= big_sign_r;
                if (sum_c[SIG_W]) begin
                    work_man <= sum_c[SIG_W:1];
                    work_exp <= $signed({2'b00, big_exp_r}) + 10'sd1;
                end else begin
                    work_man <= sum_c[SIG_W-1:0];
                    work_exp <= $signed({2'b00, big_exp_r});
                end
            end
            NORM: begin
                if (!norm_done) begin
                    work_man <= work_man << 1;
                    work_exp <= work_exp - 10'sd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= F32_ZERO;
            special  <= 1'b0;
            out_data <= F32_ZERO;
        end else if ((state == NORM) && norm_done) begin
            acc     <= result;
            special <= (result[EXP_HI:EXP_LO] == EXP_SPECIAL);
            if (last_r)
                out_data <= result;
        end else if ((state == OUT) && out_ready) begin
            acc     <= F32_ZERO;
            special <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    next_state = ALIGN;
            end
            ALIGN: next_state = ADD;
            ADD:   next_state = NORM;
            NORM: begin
                if (norm_done)
                    next_state = last_r ? OUT : IDLE;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_float32_acc.sv
// Bench for float32_acc: directed vector table, stall/reset sequences and
// random groups scored against a plain-arithmetic accumulation model.
module tb_float32_acc;
    import float32_acc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    float32_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Accumulation model: sign/magnitude arithmetic on integers, truncating.
    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] x,
                                          output int shifts);
        logic [7:0] ea, ex;
        longint ma, mx, mb, ms, tot;
        bit sa, sx, sb, ss;
        int eb, es, d, e;
        shifts = 0;
        ea = a[30:23];
        ex = x[30:23];
        if (ea == 8'hFF || ex == 8'hFF) begin
            if ((ea == 8'hFF && a[22:0] != 0) || (ex == 8'hFF && x[22:0] != 0))
                return 32'h7FC00000;
            if (ea == 8'hFF && ex == 8'hFF)
                return (a[31] == x[31]) ? a : 32'h7FC00000;
            if (ex == 8'hFF)
                return {x[31], 31'h7F800000};
            return a;
        end
        ma = (ea == 0) ? 0 : ((longint'(1) << 23) | longint'(a[22:0]));
        mx = (ex == 0) ? 0 : ((longint'(1) << 23) | longint'(x[22:0]));
        sa = (ea == 0) ? 1'b0 : a[31];
        sx = (ex == 0) ? 1'b0 : x[31];
        if (ea != 0 && (ex == 0 || ea > ex || (ea == ex && ma >= mx))) begin
            mb = ma; sb = sa; eb = ea; ms = mx; ss = sx; es = ex;
        end else begin
            mb = mx; sb = sx; eb = ex; ms = ma; ss = sa; es = ea;
        end
        d  = eb - es;
        ms = (d >= 25) ? 0 : (ms >> d);
        tot = (sb == ss) ? mb + ms : mb - ms;
        e = eb;
        if (tot == 0)
            return 32'h0;
        if (tot >= (longint'(1) << 24)) begin
            tot = tot >> 1;
            e++;
        end
        if (e >= 255)
            return {sb, 31'h7F800000};
        while (tot < (longint'(1) << 23)) begin
            tot = tot << 1;
            e--;
            shifts++;
        end
        if (e < 1)
            return 32'h0;
        return {sb, 8'(e), tot[22:0]};
    endfunction

    // Transfer one operand, then count busy cycles until in_ready or out_valid.
    task automatic send(input logic [31:0] d, input bit last, output int busy);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready)
            chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready || out_valid)
                break;
            busy++;
        end
    endtask

    task automatic recv(input string name, input logic [31:0] exp);
        chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk(name, out_data, exp);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          two;
        logic [31:0] res;
        int          busy_last;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] rand_op(input logic [31:0] prev, input bit have_prev);
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)
            return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
        if (r <= 2 && have_prev)
            return {~prev[31], prev[30:0] ^ 31'($urandom_range(0, 255))};
        return {1'($urandom_range(0, 1)), 8'(EXP_BIAS - 8 + $urandom_range(0, 16)), 23'($urandom)};
    endfunction

    initial begin
        int busy, sh, n;
        logic [31:0] m_acc, op, prev;

        tbl[0] = '{32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, 3};
        tbl[1] = '{32'h42A00000, 32'hC2A00000, 1'b1, 32'h00000000, 3};
        tbl[2] = '{32'h4F000000, 32'hBF800000, 1'b1, 32'h4F000000, 3};
        tbl[3] = '{32'h3F800000, 32'hBF000000, 1'b1, 32'h3F000000, 4};
        tbl[4] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 3};
        tbl[5] = '{32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00000, 3};
        tbl[6] = '{32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 3};
        tbl[7] = '{32'hC0490FDB, 32'h00000000, 1'b0, 32'hC0490FDB, 3};
        tbl[8] = '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7FC00000, 3};
        tbl[9] = '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 3};

        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data,           32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].two) begin
                send(tbl[i].a, 1'b0, busy);
                chk($sformatf("vec%0d_busy_a", i), busy, 3);
                send(tbl[i].b, 1'b1, busy);
            end else begin
                send(tbl[i].a, 1'b1, busy);
            end
            chk($sformatf("vec%0d_busy_last", i), busy, tbl[i].busy_last);
            recv($sformatf("vec%0d_sum", i), tbl[i].res);
        end

        // Output stall with in_valid pressure that must be ignored
        out_ready = 1'b0;
        send(32'h40000000, 1'b1, busy);
        chk("stall_busy", busy, 3);
        chk("stall_first", out_data, 32'h40000000);
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_ready", {31'b0, in_ready},  32'd0);
            chk("stall_data",  out_data,           32'h40000000);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_out_data",  out_data,           32'h40000000);
        chk("post_in_ready",  {31'b0, in_ready},  32'd1);

        // Reset during a long NORM (1.0 - 0.99999994 needs 23 shifts)
        send(32'h3F800000, 1'b0, busy);
        chk("pre_rst_busy", busy, 3);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hBF7FFFFF;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midnorm_in_ready",  {31'b0, in_ready},  32'd1);
        chk("midnorm_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midnorm_out_data",  out_data,           32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h40400000, 1'b1, busy);
        chk("after_rst_busy", busy, 3);
        recv("after_rst_sum", 32'h40400000);

        // Random groups against the model
        for (int g = 0; g < 40; g++) begin
            n = $urandom_range(1, 4);
            m_acc = 32'h0;
            prev  = 32'h0;
            for (int i = 0; i < n; i++) begin
                op    = rand_op(prev, i > 0);
                prev  = op;
                m_acc = m_add(m_acc, op, sh);
                send(op, i == n - 1, busy);
                chk($sformatf("rnd%0d_op%0d_busy", g, i), busy, 3 + sh);
            end
            recv($sformatf("rnd%0d_sum", g), m_acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/float32_acc.md
FLOAT32_ACC -- requirements
Module: float32_acc

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  in_data/in_last are valid this cycle.
REQ-005 in_data  input  32  IEEE-754 binary32 operand, typically from the int2float32 stage.
REQ-006 in_last  input  1  operand closes the current accumulation group.
REQ-007 in_ready  output  1  block can accept an operand this cycle.
REQ-008 out_valid  output  1  out_data holds a completed group sum.
REQ-009 out_data  output  32  binary32 group sum.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-011 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, OUT; in_ready=1 only in IDLE.
REQ-012 SHALL transfer an operand on in_valid&in_ready; operand and in_last registered; IDLE->ALIGN.
REQ-013 SHALL add each operand to internal accumulator acc, initialised to +0 (0x00000000).
REQ-014 SHALL treat exponent field 0 as zero (denormals flushed, sign ignored); normals use 24-bit mantissa with hidden 1.
REQ-015 ALIGN: smaller-magnitude operand mantissa right-shifted by exponent difference, shifted-out bits discarded; difference >=25 -> smaller operand zero; 1 cycle, ->ADD.
REQ-016 ADD: equal signs add, else subtract smaller from larger magnitude, result sign of larger (equal magnitudes -> +0); 25-bit result; carry-out -> shift right 1, exponent+1; 1 cycle, ->NORM.
REQ-017 NORM: while mantissa nonzero and bit 23 clear, shift left 1 and exponent-1 per cycle; writes acc and exits when bit 23 set or mantissa zero; NORM occupancy = 1 + shift count (max 24 cycles).
REQ-018 Rounding SHALL be truncation (toward zero); no guard/sticky bits.
REQ-019 Zero mantissa result or exponent underflow (<1) SHALL give acc=+0.
REQ-020 Exponent >=255 after ADD SHALL saturate acc to signed infinity (0x7F800000/0xFF800000); further finite operands leave infinity unchanged; +inf plus -inf -> canonical NaN.
REQ-021 Any operand with exponent 255 SHALL set a sticky special flag: infinity input behaves as REQ-020, NaN input forces group result 0x7FC00000.
REQ-022 NORM exit: registered in_last=1 -> OUT, else IDLE.
REQ-023 OUT: out_valid=1, out_data=acc held stable until out_valid&out_ready; then acc=+0, flags cleared, ->IDLE.
REQ-024 out_valid SHALL be 0 in all states other than OUT; out_data SHALL hold last value outside OUT.
REQ-025 in_valid in non-IDLE states SHALL be ignored (no transfer); upstream holds data per handshake.
REQ-026 Single-operand group with in_last SHALL output that operand (denormal input -> +0).

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, acc=+0, flags cleared, in_ready=1, out_valid=0, out_data=0, regardless of state (incl. mid-NORM or OUT).
REQ-028 First transfer after rst_n rises SHALL be possible on the first clk edge with rst_n high.

Structure
REQ-029 Shared package SHALL hold: float32 field widths/positions (sign 31, exp 30:23, man 22:0), exponent bias 127, state enumeration, canonical NaN 0x7FC00000, infinity constants.
REQ-030 One sub-module SHALL be f32_unpack (combinational: sign, exponent, 24-bit mantissa, is_zero, is_inf, is_nan); used for both in_data and acc.
REQ-031 Everything else inside float32_acc; single clock domain.

Verification
REQ-032 Group 0x3F800000 (1.0), 0x40000000 (2.0, in_last) -> out_data 0x40400000; per-operand cycles IDLE->ALIGN->ADD->NORM checked.
REQ-033 Group 0x42A00000 (80.0), 0xC2A00000 (-80.0, last) -> 0x00000000; second operand NORM lasts 1 cycle (zero result).
REQ-034 Group 0x4F000000, 0xBF800000 (last) -> 0x4F000000 (difference 31, truncated); group 0x3F800000, 0xBF000000 (last) -> 0x3F000000, NORM 2 cycles.
REQ-035 Group 0x7F7FFFFF, 0x7F7FFFFF (last) -> 0x7F800000; group 0x7FC00001, 0x3F800000 (last) -> 0x7FC00000.
REQ-036 out_ready low 5 cycles in OUT -> out_valid/out_data stable, in_ready=0; assert rst_n low mid-NORM -> in_ready=1, out_valid=0 same cycle, next group 0x40400000 (last) -> 0x40400000.
